// File: rtl/cam_threshold_capture.sv
// Camera-domain producer: parses VSYNC/HREF/YUV422 bytes, binarises luma against a
// per-frame threshold and writes one bit per pixel into the frame buffer.
module cam_threshold_capture #(
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240,
   parameter int ADDR_W   = 17
) (
   input  logic              w_clk,
   input  logic              w_rst_n,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   input  logic [7:0]        i_threshold,
   input  logic              i_invert,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_data,
   output logic              frame_done,
   output logic              frame_err,
   output logic [8:0]        line_count,
   output logic [1:0]        fsm_state
);

   localparam int                COL_W  = $clog2(H_PIXELS + 1);
   localparam logic [COL_W-1:0]  H_COL  = COL_W'(H_PIXELS);
   localparam logic [8:0]        V_LN   = 9'(V_LINES);
   localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_PIXELS);

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      BLANK     = 2'd1,
      ACTIVE    = 2'd2,
      FRAME_END = 2'd3
   } state_t;

   state_t            state;
   state_t            state_d;
   logic              s1_vsync;
   logic              s1_href;
   logic [7:0]        s1_data;
   logic              vsync_q;
   logic              href_q;
   logic              phase;
   logic [COL_W-1:0]  col;
   logic [8:0]        line;
   logic [ADDR_W-1:0] line_base;
   logic              err_flag;
   logic [7:0]        thr_q;
   logic              inv_q;

   logic vs_rise;
   logic vs_fall;
   logic href_fall;
   logic line_end;
   logic y_byte;
   logic col_ok;
   logic line_ok;
   logic pix_keep;
   logic pix_write;

   assign fsm_state = state;

   assign vs_rise   = s1_vsync & ~vsync_q;
   assign vs_fall   = ~s1_vsync & vsync_q;
   assign href_fall = ~s1_href & href_q;
   assign col_ok    = (col < H_COL);
   assign line_ok   = (line < V_LN);

   // A vsync rise while href is still high closes the line before the frame ends.
   assign line_end  = (state == ACTIVE) && (href_fall || (vs_rise && s1_href));
   assign y_byte    = (state == ACTIVE) && s1_href && !phase && !vs_rise;
   assign pix_keep  = y_byte && col_ok;
   assign pix_write = pix_keep && line_ok;

   always_comb begin
      state_d = state;
      case (state)
         WAIT_SYNC: if (vs_rise) state_d = BLANK;
         BLANK:     if (vs_fall) state_d = ACTIVE;
         ACTIVE:    if (vs_rise) state_d = FRAME_END;
         FRAME_END: state_d = BLANK;
         default:   state_d = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state      <= WAIT_SYNC;
         s1_vsync   <= 1'b0;
         s1_href    <= 1'b0;
         s1_data    <= 8'd0;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         phase      <= 1'b0;
         col        <= '0;
         line       <= 9'd0;
         line_base  <= '0;
         err_flag   <= 1'b0;
         thr_q      <= 8'd0;
         inv_q      <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         line_count <= 9'd0;
      end else begin
         s1_vsync   <= cam_vsync;
         s1_href    <= cam_href;
         s1_data    <= cam_data;
         vsync_q    <= s1_vsync;
         href_q     <= s1_href;
         state      <= state_d;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         phase      <= s1_href ? ~phase : 1'b0;

         // Threshold and polarity are frozen for the whole frame at vsync fall.
         if (state == BLANK && vs_fall) begin
            thr_q     <= i_threshold;
            inv_q     <= i_invert;
            line      <= 9'd0;
            col       <= '0;
            line_base <= '0;
            phase     <= 1'b0;
            err_flag  <= 1'b0;
         end

         if (pix_keep) col <= col + COL_W'(1);

         if (pix_write) begin
            wr_en   <= 1'b1;
            wr_addr <= line_base + ADDR_W'(col);
            wr_data <= (s1_data >= thr_q) ^ inv_q;
         end

         if (y_byte && !col_ok) err_flag <= 1'b1;

         if (line_end) begin
            if (col != H_COL) err_flag <= 1'b1;
            if (line != 9'd511) line <= line + 9'd1;
            // Base stops advancing past the last stored line, so it never wraps.
            if (line_ok) line_base <= line_base + H_ADDR;
            col   <= '0;
            phase <= 1'b0;
         end

         if (state == FRAME_END) begin
            if (!err_flag && line == V_LN) frame_done <= 1'b1;
            else                           frame_err  <= 1'b1;
            line_count <= line;
         end
      end
   end

endmodule

// File: tb/tb_cam_threshold_capture.sv
// Directed bench for cam_threshold_capture on a reduced 8x6 geometry; expected writes
// are queued by the byte driver and popped by a monitor on every wr_en.
module tb_cam_threshold_capture;

   localparam int H  = 8;
   localparam int V  = 6;
   localparam int AW = 6;
   localparam int W  = AW + 1;

   logic          w_clk;
   logic          w_rst_n;
   logic          cam_vsync;
   logic          cam_href;
   logic [7:0]    cam_data;
   logic [7:0]    i_threshold;
   logic          i_invert;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          wr_data;
   logic          frame_done;
   logic          frame_err;
   logic [8:0]    line_count;
   logic [1:0]    fsm_state;

   cam_threshold_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_data    (cam_data),
      .i_threshold (i_threshold),
      .i_invert    (i_invert),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .line_count  (line_count),
      .fsm_state   (fsm_state)
   );

   // clock / timeout
   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (got running, expected done)");
      $fatal(1, "timeout");
   end

   // scoreboard state
   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_wr_cyc = -100;
   int done_cnt = 0;
   int err_cnt = 0;
   int frame_thr;
   int frame_inv;
   bit pend_valid = 0;
   int pend_done;
   int pend_err;
   int pend_lc;
   int pend_done_base;
   int pend_err_base;
   bit pend_wr;
   int pend_last_addr;
   int last_push_addr;
   bit pushed;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge w_clk) begin
      if (w_rst_n) begin
         logic [W-1:0] e;
         cyc++;
         if (wr_en) begin
            check("wr_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e[W-1:1]));
               check("wr_data", 32'(wr_data), 32'(e[0]));
            end
            last_wr_cyc = cyc;
         end
         if (frame_done || frame_err) check("end_gap", 32'((cyc - last_wr_cyc) >= 2), 1);
         if (frame_done) done_cnt++;
         if (frame_err) err_cnt++;
      end
   end

   // drivers
   task automatic drive(input logic v, input logic h, input logic [7:0] d);
      @(negedge w_clk);
      cam_vsync = v;
      cam_href  = h;
      cam_data  = d;
   endtask

   task automatic check_pending();
      if (pend_valid) begin
         check("frame_done_cnt", 32'(done_cnt - pend_done_base), 32'(pend_done));
         check("frame_err_cnt", 32'(err_cnt - pend_err_base), 32'(pend_err));
         check("line_count", 32'(line_count), 32'(pend_lc));
         check("exp_q_empty", 32'(exp_q.size()), 0);
         if (pend_wr) check("wr_addr_hold", 32'(wr_addr), 32'(pend_last_addr));
         pend_valid = 0;
      end
   endtask

   task automatic send_line(input int l, input int n, input int npix, input bit en);
      for (int p = 0; p < n; p++) begin
         logic [7:0] y;
         logic       b;
         y = 8'(((l * npix + p) * 5) % 256);
         if (en && p < H && l < V) begin
            b = ((int'(y) >= frame_thr) ? 1'b1 : 1'b0) ^ frame_inv[0];
            last_push_addr = l * H + p;
            pushed = 1;
            exp_q.push_back({AW'(last_push_addr), b});
         end
         drive(1'b0, 1'b1, y);
         drive(1'b0, 1'b1, 8'h80);
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int nlines, input int npix, input int short_line,
                             input int thr, input int inv, input int mid_thr,
                             input int rel_line, input bit en);
      bit ok;
      repeat (6) drive(1'b1, 1'b0, 8'h00);
      check_pending();
      i_threshold = 8'(thr);
      i_invert    = inv[0];
      frame_thr   = thr;
      frame_inv   = inv;
      pushed      = 0;
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      for (int l = 0; l < nlines; l++) begin
         if (l == rel_line) w_rst_n = 1'b1;
         if (l == 2 && mid_thr >= 0) i_threshold = 8'(mid_thr);
         send_line(l, (l == short_line) ? npix - 1 : npix, npix, en);
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      ok = (nlines == V) && (npix == H) && (short_line < 0);
      pend_valid     = 1;
      pend_done      = (en && ok) ? 1 : 0;
      pend_err       = (en && !ok) ? 1 : 0;
      pend_lc        = en ? nlines : 0;
      pend_done_base = done_cnt;
      pend_err_base  = err_cnt;
      pend_wr        = pushed;
      pend_last_addr = last_push_addr;
   endtask

   task automatic end_frames();
      repeat (6) drive(1'b1, 1'b0, 8'h00);
      check_pending();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en), 0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 0);
      check({tag, "_wr_data"}, 32'(wr_data), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_frame_err"}, 32'(frame_err), 0);
      check({tag, "_line_count"}, 32'(line_count), 0);
      check({tag, "_state"}, 32'(fsm_state), 0);
   endtask

   initial begin
      w_rst_n     = 1'b0;
      cam_vsync   = 1'b0;
      cam_href    = 1'b0;
      cam_data    = 8'h00;
      i_threshold = 8'd0;
      i_invert    = 1'b0;
      repeat (3) @(negedge w_clk);
      check_idle_outputs("reset");
      w_rst_n = 1'b1;
      repeat (2) drive(1'b0, 1'b0, 8'h00);

      // ramp, thr 128
      send_frame(V, H, -1, 128, 0, -1, -1, 1);
      // inverted, thr 0: every pixel 0
      send_frame(V, H, -1, 0, 1, -1, -1, 1);
      // line 2 one pixel short: line 3 still starts at 3*H
      send_frame(V, H, 2, 128, 0, -1, -1, 1);
      // too many lines and too many pixels per line
      send_frame(V + 2, H + 2, -1, 100, 0, -1, -1, 1);
      // threshold changes mid-frame, takes effect next frame
      send_frame(V, H, -1, 50, 0, 200, -1, 1);
      send_frame(V, H, -1, 200, 0, -1, -1, 1);
      end_frames();

      // asynchronous reset mid-stream, released during the active part of frame 0
      @(negedge w_clk);
      w_rst_n = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      send_frame(V, H, -1, 128, 0, -1, 1, 0);
      send_frame(V, H, -1, 90, 0, -1, -1, 1);
      send_frame(V, H, -1, 30, 1, -1, -1, 1);
      end_frames();
      repeat (4) drive(1'b0, 1'b0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cam_threshold_capture.md
Name: cam_threshold_capture

Overview:
- Camera-domain producer for the double-buffered SPRAM frame buffer.
- Parses OV7670-style parallel video (VSYNC/HREF/8-bit data, YUV422, luma byte first) clocked by cam_pclk.
- Binarises luma against a runtime threshold and emits one 1-bit pixel per write, plus an end-of-frame pulse.
- Emits frame_done only for geometrically complete frames, so the buffer swaps banks only on valid frames.

Parameters:
- H_PIXELS, 320, active pixels per line written to the buffer.
- V_LINES, 240, active lines per frame written to the buffer.
- ADDR_W, 17, pixel address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- w_clk  in  1  pixel clock (cam_pclk, ~2.5 MHz); all logic on rising edge.
- w_rst_n  in  1  asynchronous, active-low reset.
- cam_vsync  in  1  high during vertical blanking.
- cam_href  in  1  high while line bytes are valid.
- cam_data  in  8  byte stream: Y0 U0 Y1 V0 ...
- i_threshold  in  8  luma threshold; quasi-static, sampled once per frame.
- i_invert  in  1  1 = dark pixels become 1; sampled once per frame.
- wr_en  out  1  one-cycle write strobe per kept pixel.
- wr_addr  out  ADDR_W  pixel index = line*H_PIXELS + col.
- wr_data  out  1  thresholded pixel.
- frame_done  out  1  one-cycle pulse at the end of a complete frame.
- frame_err  out  1  one-cycle pulse at the end of a malformed frame.
- line_count  out  9  lines seen in the last finished frame, saturating at 511.

Behaviour:
- Reset: all outputs 0, FSM = WAIT_SYNC, all counters 0.
- Input stage: cam_vsync, cam_href and cam_data registered once (s1_*); all decisions use s1_*.
  - vs_rise / vs_fall: s1_vsync differs from its previous registered value.
  - href_fall: same rule applied to s1_href (1 to 0).
- FSM states:
  - WAIT_SYNC: ignore data until vs_rise, then go to BLANK. Discards any partial frame after reset.
  - BLANK: on vs_fall, latch i_threshold and i_invert, clear line/col/line_base/phase/err_flag, go to ACTIVE.
  - ACTIVE: capture pixels; on vs_rise go to END.
  - END: single cycle. Pulse frame_done if err_flag==0 and lines==V_LINES, else pulse frame_err. Update line_count, then go to BLANK.
- Byte phase:
  - phase toggles on every cycle with s1_href=1; cleared when s1_href=0.
  - phase 0 = Y byte (luma), phase 1 = chroma (ignored).
- Pixel write:
  - Condition: in ACTIVE, s1_href=1, phase==0, col<H_PIXELS and line<V_LINES.
  - Next edge: wr_en=1, wr_addr=line_base+col, wr_data=(Y>=thr)^inv, and col increments.
  - Latency: one cycle from s1 capture of the Y byte to the wr_en edge, i.e. two w_clk edges from the cam_data pin.
- Overflow:
  - Bytes with col>=H_PIXELS: dropped, err_flag set.
  - Lines with line>=V_LINES: dropped entirely, but still counted.
- Line end (href_fall in ACTIVE):
  - If col!=H_PIXELS, set err_flag.
  - line increments, saturating at 511.
  - line_base += H_PIXELS; col=0; phase=0.
- Width rules:
  - line_base and wr_addr are ADDR_W bits.
  - Max written address = H_PIXELS*V_LINES-1 (76799); no wrap.
- Odd byte count on a line: the trailing Y is written normally, and col is checked at href_fall.
- Ordering:
  - frame_done/frame_err is never asserted in the same cycle as wr_en.
  - It trails the last wr_en by at least 2 cycles, which the END state guarantees.
- Simultaneous events:
  - vs_rise with s1_href=1: the line is treated as ended (href_fall semantics applied first, including err_flag check), then END.
  - vs_fall outside BLANK: ignored.
- Mid-operation changes:
  - i_threshold/i_invert changes mid-frame have no effect until the next vs_fall.
  - Reset mid-frame: outputs drop immediately; no frame_done until a full frame after the next vs_rise.
- wr_data and wr_addr hold their last values when wr_en=0.

Test Plan:
- Full 320x240 frame, Y ramp 0..255, thr=128, inv=0:
  - 76800 wr_en pulses, addresses 0..76799 strictly increasing.
  - wr_data=1 exactly where Y>=128.
  - One frame_done, line_count=240.
- Same frame with inv=1, thr=0: all wr_data=0; frame_done pulses.
- Reset released mid-ACTIVE of frame 0, then frames 1 and 2 complete:
  - No wr_en before frame 1's vs_fall.
  - frame_done only after frames 1 and 2.
- Frame with line 10 carrying 319 pixels:
  - Line 11 pixel 0 written at addr 3520.
  - End of frame gives frame_err=1, frame_done=0.
- Frame with 245 lines of 330 pixels:
  - Only cols 0..319 and lines 0..239 written.
  - frame_err pulse, line_count=245.
- i_threshold changed 50 -> 200 mid-frame:
  - Current frame keeps using 50.
  - Next frame uses 200.
  - frame_done trails the last wr_en by >=2 cycles.
